// File: rtl/cipher_byte_streamer.sv
// cipher_byte_streamer
// Buffers 64-bit ciphertext blocks in a small FIFO and serializes them
// MSB-first as bytes. A per-block byte count truncates partial blocks and
// a last flag marks the final byte of the message.
//
// Handshakes: both interfaces use valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both high. The producer of
// valid keeps data stable until the transfer. wr_ready_o depends only on
// registered occupancy, and byte_valid_o/byte_o/byte_last_o depend only on
// registered serializer state, so neither output combinationally depends
// on the partner's valid or ready.
module cipher_byte_streamer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid_i,
  input  logic [63:0]                wr_data_i,
  input  logic [3:0]                 wr_nbytes_i,
  input  logic                       wr_last_i,
  output logic                       wr_ready_o,
  output logic [7:0]                 byte_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic                       byte_last_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       busy_o,
  output logic                       dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  // FIFO storage
  logic [63:0]   mem_data_q [DEPTH];
  logic [3:0]    mem_nb_q   [DEPTH];
  logic          mem_last_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Serializer
  state_e        state_q, state_d;
  logic [63:0]   shift_q, shift_d;
  logic [3:0]    nb_q, nb_d;
  logic          last_q, last_d;
  logic [2:0]    idx_q, idx_d;
  logic          busy_q, busy_d;

  logic          push;
  logic          pop;
  logic          fifo_ne;
  logic          at_end;
  logic [3:0]    wr_nb_norm;

  // Zero or out-of-range byte counts mean a full block.
  assign wr_nb_norm = ((wr_nbytes_i == 4'd0) || (wr_nbytes_i > 4'd8)) ? 4'd8 : wr_nbytes_i;

  assign fifo_ne = (count_q != '0);
  assign push    = wr_valid_i && (count_q != CW'(DEPTH));
  assign at_end  = ({1'b0, idx_q} == (nb_q - 4'd1));

  // FIFO write port; storage needs no reset because count gates all reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= wr_data_i;
      mem_nb_q[wr_ptr_q]   <= wr_nb_norm;
      mem_last_q[wr_ptr_q] <= wr_last_i;
    end
  end

  // Serializer next-state, pop decision and occupancy bookkeeping.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    nb_d     = nb_q;
    last_d   = last_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (byte_ready_i) begin
          if (!at_end) begin
            shift_d = {shift_q[55:0], 8'h00};
            idx_d   = idx_q + 3'd1;
          end else if (fifo_ne) begin
            // Back-to-back: next block loads on the same edge, no bubble.
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_data_q[rd_ptr_q];
      nb_d     = mem_nb_q[rd_ptr_q];
      last_d   = mem_last_q[rd_ptr_q];
      idx_d    = 3'd0;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Busy reflects the state being entered so it updates with push/pop.
  always_comb begin
    busy_d = (count_d != '0) || (state_d == S_SHIFT);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      nb_q     <= 4'd8;
      last_q   <= 1'b0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      nb_q     <= nb_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Outputs come straight from registers; byte is forced to zero when idle.
  always_comb begin
    byte_valid_o = (state_q == S_SHIFT);
    byte_o       = (state_q == S_SHIFT) ? shift_q[63:56] : 8'h00;
    byte_last_o  = (state_q == S_SHIFT) && last_q && at_end;
    wr_ready_o   = (count_q != CW'(DEPTH));
    count_o      = count_q;
    busy_o       = busy_q;
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_cipher_byte_streamer.sv
// Self-checking bench for cipher_byte_streamer: directed scenarios plus a
// randomized run, with every emitted byte compared against a byte-level
// model built from the pushed blocks.
module tb_cipher_byte_streamer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid_i = 1'b0;
  logic [63:0]   wr_data_i = '0;
  logic [3:0]    wr_nbytes_i = '0;
  logic          wr_last_i = 1'b0;
  logic          wr_ready_o;
  logic [7:0]    byte_o;
  logic          byte_valid_o;
  logic          byte_ready_i = 1'b0;
  logic          byte_last_o;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          dbg_state_o;

  cipher_byte_streamer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .wr_nbytes_i  (wr_nbytes_i),
    .wr_last_i    (wr_last_i),
    .wr_ready_o   (wr_ready_o),
    .byte_o       (byte_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .byte_last_o  (byte_last_o),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // scoreboard: expected {last, byte} in emission order
  logic [8:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  int hs_cnt     = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a block contributes its first n bytes, MSB first.
  task automatic model_add(input logic [63:0] d, input logic [3:0] n, input logic l);
    int nb;
    logic [7:0] b;
    nb = (n == 0 || n > 8) ? 8 : int'(n);
    for (int i = 0; i < nb; i++) begin
      b = 8'((d >> (56 - 8 * i)) & 64'hFF);
      exp_q.push_back({(l && (i == nb - 1)), b});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one push for one edge; add marks whether the model expects it accepted.
  task automatic push_blk(input logic [63:0] d, input logic [3:0] n, input logic l, input bit add);
    wr_valid_i  = 1'b1;
    wr_data_i   = d;
    wr_nbytes_i = n;
    wr_last_i   = l;
    if (add) model_add(d, n, l);
    step();
    wr_valid_i  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 300; c++) begin
      if (exp_q.size() == 0 && !busy_o && !byte_valid_o) break;
      step();
    end
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Output monitor: scoreboard on handshakes, stability under backpressure.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic [8:0] e;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(byte_valid_o), 64'd1);
        check("stall_byte", 64'(byte_o), 64'(prev_byte));
        check("stall_last", 64'(byte_last_o), 64'(prev_last));
      end
      if (byte_valid_o && byte_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 64'(byte_o), 64'h1FF);
        end else begin
          e = exp_q.pop_front();
          check("byte", 64'(byte_o), 64'(e[7:0]));
          check("last", 64'(byte_last_o), 64'(e[8]));
        end
        hs_cnt++;
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_byte  = byte_o;
      prev_last  = byte_last_o;
    end
  end

  initial begin
    int start;
    // reset phase
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(byte_valid_o), 64'd0);
    check("rst_byte", 64'(byte_o), 64'd0);
    reset = 1'b0;
    step();
    check("rst_last", 64'(byte_last_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd1);
    check("rst_state", 64'(dbg_state_o), 64'd0);

    // single full block: valid two edges after the push, 8 back-to-back bytes
    byte_ready_i = 1'b1;
    push_blk(64'h0123456789ABCDEF, 4'd8, 1'b1, 1'b1);
    @(negedge clk);
    check("lat_valid_n", 64'(byte_valid_o), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("single_valid", 64'(byte_valid_o), 64'd1);
    end
    @(negedge clk);
    check("single_end_valid", 64'(byte_valid_o), 64'd0);
    check("single_end_busy", 64'(busy_o), 64'd0);
    step();
    wait_drain("single");

    // partial last block, no gap across the boundary
    push_blk(64'hAABBCCDD00000000, 4'd8, 1'b0, 1'b1);
    push_blk(64'h1122330000000000, 4'd3, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("partial_valid", 64'(byte_valid_o), 64'd1);
    end
    @(negedge clk);
    check("partial_end_valid", 64'(byte_valid_o), 64'd0);
    step();
    wait_drain("partial");

    // backpressure pattern 1,0,0,1,...
    byte_ready_i = 1'b0;
    start = hs_cnt;
    push_blk(64'hF0E1D2C3B4A59687, 4'd8, 1'b1, 1'b1);
    for (int c = 0; c < 40; c++) begin
      byte_ready_i = ((c % 3) == 0);
      step();
    end
    byte_ready_i = 1'b1;
    wait_drain("bp");
    check("bp_count", 64'(hs_cnt - start), 64'd8);

    // full FIFO: one block in the serializer, four queued, sixth dropped
    byte_ready_i = 1'b0;
    start = hs_cnt;
    for (int b = 0; b < 5; b++) begin
      push_blk({8'(b), 56'h11223344556677}, 4'd8, (b == 4), 1'b1);
    end
    check("full_count", 64'(count_o), 64'(DEPTH));
    check("full_wr_ready", 64'(wr_ready_o), 64'd0);
    push_blk(64'hDEADBEEFDEADBEEF, 4'd8, 1'b1, 1'b0);
    check("full_count_after_drop", 64'(count_o), 64'(DEPTH));
    byte_ready_i = 1'b1;
    wait_drain("full");
    check("full_bytes", 64'(hs_cnt - start), 64'd40);
    check("full_count_end", 64'(count_o), 64'd0);

    // nbytes normalization
    start = hs_cnt;
    push_blk(64'h0102030405060708, 4'd0, 1'b1, 1'b1);
    push_blk(64'h8877665544332211, 4'd12, 1'b1, 1'b1);
    wait_drain("norm");
    check("norm_bytes", 64'(hs_cnt - start), 64'd16);

    // reset mid-message after three bytes
    start = hs_cnt;
    push_blk(64'hA1A2A3A4A5A6A7A8, 4'd8, 1'b0, 1'b1);
    push_blk(64'hB1B2B3B4B5B6B7B8, 4'd5, 1'b1, 1'b1);
    for (int c = 0; c < 50; c++) begin
      if (hs_cnt >= start + 3) break;
      @(negedge clk);
    end
    check("rst_mid_reached", 64'(hs_cnt - start >= 3), 64'd1);
    @(posedge clk);
    #2;
    check("rst_mid_valid_before", 64'(byte_valid_o), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(byte_valid_o), 64'd0);
    check("rst_mid_byte", 64'(byte_o), 64'd0);
    check("rst_mid_last", 64'(byte_last_o), 64'd0);
    check("rst_mid_count", 64'(count_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    check("rst_mid_wr_ready", 64'(wr_ready_o), 64'd1);
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
    start = hs_cnt;
    push_blk(64'hC0C1C2C3C4C5C6C7, 4'd8, 1'b1, 1'b1);
    wait_drain("post_rst");
    check("post_rst_bytes", 64'(hs_cnt - start), 64'd8);

    // randomized traffic with random backpressure
    begin
      int sent;
      logic [63:0] d;
      logic [3:0]  n;
      logic        l;
      sent = 0;
      for (int c = 0; c < 3000 && sent < 40; c++) begin
        byte_ready_i = ($urandom_range(0, 3) != 0);
        if (wr_ready_o && $urandom_range(0, 1) == 1) begin
          d = {$urandom, $urandom};
          n = 4'($urandom_range(0, 15));
          l = 1'($urandom_range(0, 1));
          wr_valid_i  = 1'b1;
          wr_data_i   = d;
          wr_nbytes_i = n;
          wr_last_i   = l;
          model_add(d, n, l);
          sent++;
        end else begin
          wr_valid_i = 1'b0;
        end
        step();
      end
      wr_valid_i   = 1'b0;
      byte_ready_i = 1'b1;
      check("rand_sent", 64'(sent), 64'd40);
      wait_drain("rand");
      check("rand_count_end", 64'(count_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cipher_byte_streamer.md
# cipher_byte_streamer

Downstream stage of the ciphertext register in the ASCON-128 datapath. Accepts each 64-bit ciphertext block when the cipher register is updated, buffers up to DEPTH blocks in a small FIFO, and serializes them MSB-first as bytes over a valid/ready stream to the output interface. A per-block byte count truncates the final, partial block, and a last flag marks the final byte of the message.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears FIFO, serializer and all outputs
- wr_valid_i  in  1  push request; same cycle as the cipher register enable
- wr_data_i  in  64  ciphertext block; byte 0 is bits [63:56]
- wr_nbytes_i  in  4  valid bytes in the block, 1..8; 0 or values above 8 are treated as 8
- wr_last_i  in  1  block is the final ciphertext block of the message
- wr_ready_o  out  1  FIFO not full
- byte_o  out  8  current output byte
- byte_valid_o  out  1  byte_o is valid
- byte_ready_i  in  1  consumer accepts the byte
- byte_last_o  out  1  byte_o is the last byte of the message
- count_o  out  $clog2(DEPTH+1)  FIFO occupancy; excludes the word held in the serializer
- busy_o  out  1  FIFO non-empty or serializer in SHIFT

## Operation
- FIFO entry is {data[63:0], nbytes[3:0], last}. Nbytes is normalized on push.
- Push: wr_valid_i & wr_ready_o at a rising edge writes the entry at the write pointer. Pointers wrap modulo DEPTH. A push while full is dropped silently and has no state effect.
- wr_ready_o = (count_o != DEPTH), computed from registered occupancy. A push is refused when full even if a pop occurs in the same cycle.
- Pop: the serializer moves the head entry into its shift register, nbytes register, last register, and byte index idx=0.
- Serializer FSM:
  - IDLE: byte_valid_o=0. If the FIFO is non-empty, pop and go to SHIFT.
  - SHIFT: byte_valid_o=1, byte_o=shift[63:56], byte_last_o = last & (idx==nbytes-1).
    - On a handshake (byte_valid_o & byte_ready_i) with idx<nbytes-1: shift left by 8 and increment idx.
    - On a handshake with idx==nbytes-1: if the FIFO is non-empty, pop and stay in SHIFT (back-to-back, no bubble). Otherwise go to IDLE.
    - Without a handshake, byte_o, byte_last_o and byte_valid_o hold stable.
- Simultaneous push and pop: occupancy is unchanged. When count is 0, a pushed entry is not visible to the serializer until the next cycle.
- Bytes with idx>=nbytes are never emitted.

## Timing
- Reset values: byte_o=0, byte_valid_o=0, byte_last_o=0, count_o=0, busy_o=0, wr_ready_o=1. The FSM is in IDLE and the pointers are 0.
- Reset asserted mid-message discards all buffered and partially sent data. byte_valid_o drops asynchronously.
- Latency: for a push at edge N into an empty, idle block, the pop occurs at edge N+1 and byte_valid_o is high after edge N+1 (2 cycles).
- Throughput: 1 byte per cycle while byte_ready_i=1, including across block boundaries.
- count_o and busy_o are registered and update on the same edge as push and pop.

## Test plan
- Single full block: push data=0x0123456789ABCDEF, nbytes=8, last=1, with byte_ready_i=1. Required: byte_valid_o rises 2 cycles after the push; bytes 01,23,45,67,89,AB,CD,EF on consecutive cycles; byte_last_o=1 only with EF; then IDLE with busy_o=0.
- Partial last block: push 0xAABBCCDD00000000 (nbytes=8, last=0), then 0x1122330000000000 (nbytes=3, last=1). Required: 11 bytes AA..DD,00,00,00,00,11,22,33 with no gap between blocks; byte_last_o only on 33.
- Backpressure: byte_ready_i toggles 1,0,0,1,... during a block. Required: byte_o and byte_last_o are stable while ready=0, no byte is lost or duplicated, and 8 bytes are emitted in total.
- Full FIFO: hold byte_ready_i=0 and push 6 blocks with DEPTH=4. Required: the first block sits in the serializer, count_o reaches 4 and wr_ready_o=0, the 6th push is dropped, and after releasing ready exactly 5 blocks (40 bytes) appear in order.
- nbytes normalization: push with nbytes=0 and with nbytes=12. Required: 8 bytes each.
- Reset mid-operation: assert reset after 3 bytes of a 2-block sequence. Required: all outputs immediately go to reset values and count_o=0. A new push after release streams correctly from byte 0.
